gaussian_window_gen: RTL and testbench

Upstream feeder for the Gaussian stage. Accepts a raster-order 8-bit pixel stream for one ROW×COL frame, keeps the last WIDTH-1 image lines in on-chip line buffers, and emits every fully interior WIDTH×WIDTH window as one packed word. The packed word has exactly the layout that gaussian_core consumes on `input_pixels`. Replaces per-window random DRAM reads with a single streaming pass over the frame.

---
 rtl/gaussian_window_gen_if.sv | 39 +++
 rtl/gaussian_window_gen.sv | 144 ++++++++++++++
 tb/tb_gaussian_window_gen.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/gaussian_window_gen_if.sv
// Pixel-stream-in / packed-window-out bundle for gaussian_window_gen.
// GAUSSIAN_WIN_COORD_EN adds the win_row/win_col coordinate signals.
interface gaussian_window_gen_if #(
    parameter int BITS  = 8,
    parameter int WIDTH = 7
);
    logic                          start;
    logic                          in_valid;
    logic                          in_ready;
    logic [BITS-1:0]               in_pixel;
    logic                          win_valid;
    logic                          win_ready;
    logic [BITS*WIDTH*WIDTH-1:0]   win_pixels;
`ifdef GAUSSIAN_WIN_COORD_EN
    logic [9:0]                    win_row;
    logic [9:0]                    win_col;
`endif
    logic                          frame_done;

`ifdef GAUSSIAN_WIN_COORD_EN
    modport master (
        output start, in_valid, in_pixel, win_ready,
        input  in_ready, win_valid, win_pixels, win_row, win_col, frame_done
    );
    modport slave (
        input  start, in_valid, in_pixel, win_ready,
        output in_ready, win_valid, win_pixels, win_row, win_col, frame_done
    );
`else
    modport master (
        output start, in_valid, in_pixel, win_ready,
        input  in_ready, win_valid, win_pixels, frame_done
    );
    modport slave (
        input  start, in_valid, in_pixel, win_ready,
        output in_ready, win_valid, win_pixels, frame_done
    );
`endif
endinterface

// File: rtl/gaussian_window_gen.sv
// Streams a raster frame through WIDTH-1 line buffers and emits every interior WIDTH x WIDTH window.
// Optional GAUSSIAN_WIN_COORD_EN adds the window's top-left row/column outputs.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting pixels, emitting windows
// DONE  | one-cycle frame_done pulse
module gaussian_window_gen #(
    parameter int BITS  = 8,
    parameter int WIDTH = 7,
    parameter int ROW   = 480,
    parameter int COL   = 640
) (
    input  logic                  clk,
    input  logic                  rst,
    gaussian_window_gen_if.slave  bus
);
    localparam int NPIX = ROW * COL;
    localparam int NW   = BITS * WIDTH * WIDTH;
    localparam int CW   = $clog2(COL);
    localparam int RW   = $clog2(ROW);
    localparam int PW   = $clog2(NPIX + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     c_q;
    logic [RW-1:0]     r_q;
    logic [PW-1:0]     pix_cnt_q;
    logic              win_valid_q;
    logic              last_q;
    logic [BITS-1:0]   sr_q [WIDTH][WIDTH];
    logic [BITS-1:0]   lb_q [WIDTH-1][COL];
    logic [BITS-1:0]   new_col [WIDTH];
    logic [NW-1:0]     win_pixels;
    logic              in_ready, frame_done;
    logic              accept, handshake, emit, last_pix;

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = RUN;
            end
            RUN: begin
                in_ready = (pix_cnt_q < PW'(NPIX)) && (!win_valid_q || bus.win_ready);
                if (win_valid_q && bus.win_ready && last_q) state_d = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept    = bus.in_valid && in_ready;
    assign handshake = win_valid_q && bus.win_ready;
    assign emit      = (r_q >= RW'(WIDTH-1)) && (c_q >= CW'(WIDTH-1));
    assign last_pix  = (r_q == RW'(ROW-1)) && (c_q == CW'(COL-1));

    // Right column of the window: line buffers oldest row first, live pixel at the bottom.
    always_comb begin
        for (int k = 0; k < WIDTH-1; k++) new_col[k] = lb_q[k][c_q];
        new_col[WIDTH-1] = bus.in_pixel;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < WIDTH-2; k++) lb_q[k][c_q] <= lb_q[k+1][c_q];
            lb_q[WIDTH-2][c_q] <= bus.in_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            r_q         <= '0;
            c_q         <= '0;
            pix_cnt_q   <= '0;
            win_valid_q <= 1'b0;
            last_q      <= 1'b0;
            for (int wr = 0; wr < WIDTH; wr++)
                for (int wc = 0; wc < WIDTH; wc++) sr_q[wr][wc] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != RUN) begin
                r_q         <= '0;
                c_q         <= '0;
                pix_cnt_q   <= '0;
                win_valid_q <= 1'b0;
                last_q      <= 1'b0;
            end else if (accept) begin
                pix_cnt_q <= pix_cnt_q + 1'b1;
                if (c_q == CW'(COL-1)) begin
                    c_q <= '0;
                    r_q <= r_q + 1'b1;
                end else begin
                    c_q <= c_q + 1'b1;
                end
                for (int wr = 0; wr < WIDTH; wr++) begin
                    for (int wc = 0; wc < WIDTH-1; wc++) sr_q[wr][wc] <= sr_q[wr][wc+1];
                    sr_q[wr][WIDTH-1] <= new_col[wr];
                end
                win_valid_q <= emit;
                last_q      <= emit && last_pix;
            end else if (handshake) begin
                win_valid_q <= 1'b0;
                last_q      <= 1'b0;
            end
        end
    end

    always_comb begin
        win_pixels = '0;
        for (int wr = 0; wr < WIDTH; wr++)
            for (int wc = 0; wc < WIDTH; wc++)
                win_pixels[(wr*WIDTH+wc)*BITS +: BITS] = sr_q[wr][wc];
    end

`ifdef GAUSSIAN_WIN_COORD_EN
    logic [9:0] win_row_q, win_col_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            win_row_q <= '0;
            win_col_q <= '0;
        end else if (state_q == RUN && accept && emit) begin
            win_row_q <= 10'(r_q - RW'(WIDTH-1));
            win_col_q <= 10'(c_q - CW'(WIDTH-1));
        end
    end

    assign bus.win_row = win_row_q;
    assign bus.win_col = win_col_q;
`endif

    assign bus.in_ready   = in_ready;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_pixels = win_pixels;
    assign bus.frame_done = frame_done;
endmodule

// File: tb/tb_gaussian_window_gen.sv
// Scoreboard bench for gaussian_window_gen on a small 8x10 frame with a 7x7 window.
module tb_gaussian_window_gen;
    localparam int BITS  = 8;
    localparam int WIDTH = 7;
    localparam int ROW   = 8;
    localparam int COL   = 10;
    localparam int NPIX  = ROW * COL;
    localparam int NW    = BITS * WIDTH * WIDTH;
    localparam int NWIN  = (ROW-WIDTH+1) * (COL-WIDTH+1);

    typedef struct {
        logic [NW-1:0] pix;
        int            row;
        int            col;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gaussian_window_gen_if #(.BITS(BITS), .WIDTH(WIDTH)) bus();

    gaussian_window_gen #(.BITS(BITS), .WIDTH(WIDTH), .ROW(ROW), .COL(COL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  frame [ROW][COL];
    exp_t        exp_q [$];

    task automatic check(input string tag, input logic [NW-1:0] got, input logic [NW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NW-1:0] build_win(int r0, int c0);
        logic [NW-1:0] w = '0;
        for (int wr = 0; wr < WIDTH; wr++)
            for (int wc = 0; wc < WIDTH; wc++)
                w[(wr*WIDTH+wc)*BITS +: BITS] = frame[r0+wr][c0+wc];
        return w;
    endfunction

    task automatic check_coords(input string tag, input int row, input int col);
`ifdef GAUSSIAN_WIN_COORD_EN
        check({tag, "_row"}, NW'(bus.win_row), NW'(row));
        check({tag, "_col"}, NW'(bus.win_col), NW'(col));
`endif
    endtask

    // mode 0: ramp r*COL+c, mode 1: random pixels. abort_after>0 resets mid-frame.
    task automatic run_frame(input int mode, input int duty, input int rdy_duty,
                             input int stall_win, input int abort_after, input bit busy_start);
        int acc = 0, hs = 0, cyc = 0, stall_left = 0;
        bit mv = 0, exp_done = 0, done_next = 0, stall_pend, busy_done = 0;
        bit exp_ready, hsk, accp, finished = 0;
        logic [NW-1:0] w;
        exp_t e;
        stall_pend = (stall_win > 0);
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++)
                frame[r][c] = (mode == 0) ? 8'(r*COL + c) : 8'($urandom_range(255));
        exp_q.delete();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.win_ready = 1'b1;
        bus.in_valid  = ($urandom_range(99) < duty);
        bus.in_pixel  = frame[0][0];
        while (!finished && cyc < 3000) begin
            #1;
            cyc++;
            check("frame_done", NW'(bus.frame_done), NW'(exp_done));
            check("win_valid", NW'(bus.win_valid), NW'(mv));
            exp_ready = (acc < NPIX) && (!mv || bus.win_ready);
            check("in_ready", NW'(bus.in_ready), NW'(exp_ready));
            if (mv && !bus.win_ready && exp_q.size() > 0)
                check("stall_hold", bus.win_pixels, exp_q[0].pix);
            if (exp_done) begin
                check("win_count", NW'(hs), NW'(NWIN));
                finished = 1;
            end else begin
                hsk  = mv && bus.win_ready;
                accp = bus.in_valid && exp_ready;
                if (hsk) begin
                    if (exp_q.size() == 0) begin
                        check("sb_empty", NW'(1), NW'(0));
                    end else begin
                        e = exp_q.pop_front();
                        w = bus.win_pixels;
                        check("win_pixels", w, e.pix);
                        check_coords("win", e.row, e.col);
                        if (mode == 0 && hs == 0) begin
                            check("first_e00", NW'(w[0 +: BITS]), NW'(0));
                            check("first_e66", NW'(w[48*BITS +: BITS]), NW'(66));
                        end
                        if (mode == 0 && hs == NWIN-1)
                            check("last_e66", NW'(w[48*BITS +: BITS]), NW'(79));
                    end
                    hs++;
                    if (hs == NWIN) done_next = 1;
                end
                if (accp) begin
                    if (acc / COL >= WIDTH-1 && acc % COL >= WIDTH-1) begin
                        e.row = acc / COL - (WIDTH-1);
                        e.col = acc % COL - (WIDTH-1);
                        e.pix = build_win(e.row, e.col);
                        exp_q.push_back(e);
                        mv = 1;
                    end else begin
                        mv = 0;
                    end
                    acc++;
                end else if (hsk) begin
                    mv = 0;
                end
                exp_done = done_next;
            end
            @(negedge clk);
            if (abort_after > 0 && acc == abort_after) begin
                rst = 1'b1;
                bus.in_valid  = 1'b0;
                bus.win_ready = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                #1;
                check("rst_in_ready", NW'(bus.in_ready), NW'(0));
                check("rst_win_valid", NW'(bus.win_valid), NW'(0));
                check("rst_win_pixels", bus.win_pixels, '0);
                bus.in_valid = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    #1;
                    check("idle_no_accept", NW'(bus.in_ready), NW'(0));
                end
                bus.in_valid = 1'b0;
                exp_q.delete();
                return;
            end
            bus.start = 1'b0;
            if (busy_start && !busy_done && acc >= 20) begin
                bus.start = 1'b1;
                busy_done = 1;
            end
            bus.in_valid = (acc < NPIX) && ($urandom_range(99) < duty);
            bus.in_pixel = (acc < NPIX) ? frame[acc / COL][acc % COL] : 8'h00;
            if (rdy_duty < 100) begin
                bus.win_ready = ($urandom_range(99) < rdy_duty);
            end else if (stall_left > 0) begin
                bus.win_ready = 1'b0;
                stall_left--;
            end else if (stall_pend && mv && hs == stall_win-1) begin
                bus.win_ready = 1'b0;
                stall_left = 4;
                stall_pend = 0;
            end else begin
                bus.win_ready = 1'b1;
            end
        end
        if (!finished) check("timeout", NW'(0), NW'(1));
        bus.in_valid = 1'b0;
        #1;
        check("done_pulse_end", NW'(bus.frame_done), NW'(0));
        check("sb_drained", NW'(exp_q.size()), NW'(0));
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pixel  = '0;
        bus.win_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_in_ready", NW'(bus.in_ready), NW'(0));
        check("reset_win_valid", NW'(bus.win_valid), NW'(0));
        check("reset_frame_done", NW'(bus.frame_done), NW'(0));
        check("reset_win_pixels", bus.win_pixels, '0);
        check_coords("reset", 0, 0);
        rst = 1'b0;

        run_frame(0, 100, 100, 0, 0, 1'b1);   // ramp, stray start mid-frame
        run_frame(0, 100, 100, 3, 0, 1'b0);   // 5-cycle stall on 3rd window
        run_frame(0, 50,  100, 0, 0, 1'b0);   // input gaps
        run_frame(0, 100, 100, 0, 40, 1'b0);  // reset after 40 pixels
        run_frame(0, 100, 100, 0, 0, 1'b0);
        run_frame(1, 50,  70,  0, 0, 1'b0);   // random pixels, random backpressure

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
